// File: rtl/frame_pkg.sv
// Shared frame-buffer geometry and drawing-state encoding.
// Used by the frame buffer, the rectangle writer and the VGA reader.
package frame_pkg;

  localparam int unsigned H_RES       = 640;
  localparam int unsigned V_RES       = 480;
  localparam int unsigned ADDR_W      = 19;
  localparam int unsigned FRAME_WORDS = H_RES * V_RES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } draw_state_t;

  // row * stride as a sum of shifted copies of row; stride is a constant,
  // so this folds into a few adders rather than a multiplier.
  function automatic logic [31:0] row_offset(input logic [8:0] row, input int unsigned stride);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 12; i++) begin
      if (stride[i]) acc = acc + (32'(row) << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/rect_clip.sv
// Combinational clip of a rectangle command against the visible frame.
// Produces half-open bounds [xs,xe) x [ys,ye) and an empty flag.
module rect_clip #(
  parameter int unsigned H_RES = frame_pkg::H_RES,
  parameter int unsigned V_RES = frame_pkg::V_RES
) (
  input  logic [9:0]  x0,
  input  logic [8:0]  y0,
  input  logic [9:0]  width,
  input  logic [8:0]  height,
  output logic [9:0]  xs,
  output logic [8:0]  ys,
  output logic [10:0] xe,
  output logic [9:0]  ye,
  output logic        empty
);

  logic [10:0] x_sum;
  logic [9:0]  y_sum;

  assign x_sum = {1'b0, x0} + {1'b0, width};
  assign y_sum = {1'b0, y0} + {1'b0, height};

  assign xs = x0;
  assign ys = y0;
  assign xe = (x_sum > 11'(H_RES)) ? 11'(H_RES) : x_sum;
  assign ye = (y_sum > 10'(V_RES)) ? 10'(V_RES) : y_sum;

  assign empty = ({1'b0, x0} >= 11'(H_RES)) || ({1'b0, y0} >= 10'(V_RES)) ||
                 (width == 10'd0) || (height == 9'd0);

endmodule

// File: rtl/rect_fill_writer.sv
// Rectangle-fill drawing stage: clips one command and streams registered
// pixel writes, one per clock in row-major order, into the frame buffer.
module rect_fill_writer
  import frame_pkg::*;
#(
  parameter int unsigned H_RES  = frame_pkg::H_RES,
  parameter int unsigned V_RES  = frame_pkg::V_RES,
  parameter int unsigned ADDR_W = frame_pkg::ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [9:0]        x0,
  input  logic [8:0]        y0,
  input  logic [9:0]        width,
  input  logic [8:0]        height,
  input  logic              color,
  output logic [ADDR_W-1:0] write_address,
  output logic              data_In,
  output logic              we,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_DRAW = DRAW;
  localparam logic [1:0] S_DONE = DONE;

  logic [9:0]  clip_xs;
  logic [8:0]  clip_ys;
  logic [10:0] clip_xe;
  logic [9:0]  clip_ye;
  logic        clip_empty;

  rect_clip #(
    .H_RES(H_RES),
    .V_RES(V_RES)
  ) u_clip (
    .x0    (x0),
    .y0    (y0),
    .width (width),
    .height(height),
    .xs    (clip_xs),
    .ys    (clip_ys),
    .xe    (clip_xe),
    .ye    (clip_ye),
    .empty (clip_empty)
  );

  logic [1:0]        state_reg;
  logic [9:0]        xs_reg;
  logic [10:0]       xe_reg;
  logic [9:0]        ye_reg;
  logic [9:0]        x_reg;
  logic [8:0]        y_reg;
  logic [ADDR_W-1:0] row_base_reg;
  logic              color_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              data_reg;
  logic              we_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              last_col;
  logic              last_row;

  assign last_col = ({1'b0, x_reg} == (xe_reg - 11'd1));
  assign last_row = ({1'b0, y_reg} == (ye_reg - 10'd1));

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_reg <= S_IDLE;
      addr_reg  <= '0;
      data_reg  <= 1'b0;
      we_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      we_reg   <= 1'b0;
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            busy_reg     <= 1'b1;
            color_reg    <= color;
            xs_reg       <= clip_xs;
            xe_reg       <= clip_xe;
            ye_reg       <= clip_ye;
            x_reg        <= clip_xs;
            y_reg        <= clip_ys;
            row_base_reg <= ADDR_W'(row_offset(clip_ys, H_RES));
            state_reg    <= clip_empty ? S_DONE : S_DRAW;
          end else begin
            busy_reg <= 1'b0;
          end
        end
        S_DRAW: begin
          we_reg   <= 1'b1;
          data_reg <= color_reg;
          addr_reg <= row_base_reg + ADDR_W'(x_reg);
          if (last_col) begin
            x_reg        <= xs_reg;
            y_reg        <= y_reg + 9'd1;
            row_base_reg <= row_base_reg + ADDR_W'(H_RES);
            if (last_row) state_reg <= S_DONE;
          end else begin
            x_reg <= x_reg + 10'd1;
          end
        end
        // done surfaces on the following cycle, with busy still high
        S_DONE: begin
          done_reg  <= 1'b1;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign write_address = addr_reg;
  assign data_In       = data_reg;
  assign we            = we_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;

endmodule
